// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the scanner FSM states and the row/column to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Entry {row, col}: row-major, element 0 is row0/col0 ('1').
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, KEY_HASH, 4'h0, KEY_STAR,
        4'hC, 4'h9,     4'h8, 4'h7,
        4'hB, 4'h6,     4'h5, 4'h4,
        4'hA, 4'h3,     4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Free-running divider: one-clk tick every CLK_DIV clocks.
// Ports: clk, reset (async, active-high), tick (out).
module tick_gen #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, debounce,
// key encode. Ports: clk, reset, row_n[3:0] in; col_n[3:0], key_code[3:0],
// key_valid (one-clk strobe per press), key_held out.
module keypad_scanner #(
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    import keypad_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic          tick;
    logic [3:0]    sync1;
    logic [3:0]    rs;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]    col_sel, col_sel_n;
    logic [1:0]    row_lat, row_lat_n;
    logic [3:0]    code_n;
    logic          valid_n;
    logic          held_n;
    logic          press;
    logic [1:0]    row_hit;
    logic          same_row;
    logic          fire;

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 4'b1111;
            rs    <= 4'b1111;
        end else begin
            sync1 <= row_n;
            rs    <= sync1;
        end
    end

    // A press is exactly one row low; anything else reads as no key.
    always_comb begin
        press   = 1'b1;
        row_hit = 2'd0;
        case (rs)
            4'b1110: row_hit = 2'd0;
            4'b1101: row_hit = 2'd1;
            4'b1011: row_hit = 2'd2;
            4'b0111: row_hit = 2'd3;
            default: press   = 1'b0;
        endcase
    end

    assign same_row = press && (row_hit == row_lat);
    assign cnt_inc  = cnt + 1'b1;
    assign col_n    = ~(4'b0001 << col_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            cnt       <= '0;
            col_sel   <= 2'd0;
            row_lat   <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            col_sel   <= col_sel_n;
            row_lat   <= row_lat_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        col_sel_n = col_sel;
        row_lat_n = row_lat;
        code_n    = key_code;
        valid_n   = 1'b0;
        held_n    = key_held;
        fire      = 1'b0;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (press) begin
                        row_lat_n = row_hit;
                        if (DEBOUNCE_TICKS == 1) begin
                            fire = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = ONE;
                        end
                    end else begin
                        col_sel_n = col_sel + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (same_row) begin
                        if (cnt_inc == DB_LAST) begin
                            fire = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        // Bounce: rescan the same column next tick.
                        cnt_n   = '0;
                        state_n = SCAN;
                    end
                end
                PRESSED: begin
                    if (!same_row) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            held_n  = 1'b0;
                            state_n = SCAN;
                            cnt_n   = '0;
                        end else begin
                            state_n = RELEASE;
                            cnt_n   = ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (!same_row) begin
                        if (cnt_inc == DB_LAST) begin
                            held_n  = 1'b0;
                            state_n = SCAN;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        // Release glitch: back to held, no new strobe.
                        cnt_n   = '0;
                        state_n = PRESSED;
                    end
                end
                default: begin
                    state_n = SCAN;
                    cnt_n   = '0;
                end
            endcase
        end
        if (fire) begin
            code_n  = key_lookup(row_hit, col_sel);
            valid_n = 1'b1;
            held_n  = 1'b1;
            state_n = PRESSED;
            cnt_n   = '0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural key matrix model.
// Ports driven: clk, reset, row_n; observed: col_n, key_code, key_valid, key_held.
module tb_keypad_scanner;

    localparam int CLK_DIV = 4;
    localparam int DB      = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] keys [4];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int viol = 0;
    logic kv_prev = 1'b0;
    logic [3:0] kq [$];

    keypad_scanner #(
        .CLK_DIV(CLK_DIV),
        .DEBOUNCE_TICKS(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Matrix: a row is pulled low when any pressed key on it sits in
    // the column currently driven low.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(keys[r] & ~col_n);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid) begin
                kq.push_back(key_code);
                if (!key_held) viol++;
                if (kv_prev) viol++;
            end
            kv_prev = key_valid;
        end else begin
            kv_prev = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * CLK_DIV) @(negedge clk);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
    endtask

    task automatic wait_kv(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_col(input logic [3:0] v, input int budget,
                            output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (col_n == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [3:0] rot [5];
    int         sk_r [7];
    int         sk_c [7];
    logic [3:0] sk_code [7];

    initial begin
        bit ok;
        int t0;
        int t1;
        logic [3:0] c0;
        logic [7:0] got;

        rot = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        sk_r = '{0, 2, 1, 1, 3, 3, 0};
        sk_c = '{0, 1, 2, 1, 2, 0, 3};
        sk_code = '{4'h1, 4'h8, 4'h6, 4'h5, 4'hF, 4'hE, 4'hA};

        // Reset values and idle rotation.
        clear_keys();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_col", col_n, 4'b1110);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        chk("rst_code", key_code, 4'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rot0", col_n, rot[0]);
        for (int i = 1; i < 5; i++) begin
            repeat (CLK_DIV) @(negedge clk);
            chk($sformatf("rot%0d", i), col_n, rot[i]);
        end

        // Clean press of '8': latency measured from col1 becoming active.
        reset = 1'b1;
        @(negedge clk);
        kq.delete();
        keys[2][1] = 1'b1;
        reset = 1'b0;
        wait_col(4'b1101, 40, ok);
        t0 = cyc;
        chk("p8_col_seen", ok, 1'b1);
        wait_kv(60, ok);
        t1 = cyc;
        chk("p8_kv_seen", ok, 1'b1);
        chk("p8_latency", t1 - t0, 12);
        chk("p8_code", key_code, 4'h8);
        ticks(18);
        chk("p8_held", key_held, 1'b1);
        chk("p8_count", kq.size(), 1);
        keys[2][1] = 1'b0;
        repeat (8) @(negedge clk);
        chk("p8_held_rel_early", key_held, 1'b1);
        repeat (7) @(negedge clk);
        chk("p8_held_rel_late", key_held, 1'b0);
        chk("p8_count_end", kq.size(), 1);

        // Bounce on '5': alternates every tick, never stable long enough.
        ticks(2);
        kq.delete();
        for (int i = 0; i < 16; i++) begin
            keys[1][1] = (i % 2 == 0);
            ticks(1);
        end
        keys[1][1] = 1'b0;
        ticks(6);
        chk("bounce_count", kq.size(), 0);
        chk("bounce_held", key_held, 1'b0);
        c0 = col_n;
        ok = 1'b0;
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            @(negedge clk);
            if (col_n != c0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bounce_rescan", ok, 1'b1);

        // Two keys in one column are ignored; dropping one accepts the other.
        kq.delete();
        keys[0][0] = 1'b1;
        keys[1][0] = 1'b1;
        ticks(20);
        chk("multi_none", kq.size(), 0);
        chk("multi_held", key_held, 1'b0);
        keys[1][0] = 1'b0;
        wait_kv(100, ok);
        chk("multi_kv_seen", ok, 1'b1);
        chk("multi_code", key_code, 4'h1);
        ticks(10);
        chk("multi_count", kq.size(), 1);
        clear_keys();
        ticks(8);
        chk("multi_rel_held", key_held, 1'b0);

        // Key sequence into the downstream FSM.
        kq.delete();
        for (int k = 0; k < 7; k++) begin
            keys[sk_r[k]][sk_c[k]] = 1'b1;
            ticks(10);
            keys[sk_r[k]][sk_c[k]] = 1'b0;
            ticks(5);
        end
        chk("seq_count", kq.size(), 7);
        for (int k = 0; k < 7; k++) begin
            got = (k < kq.size()) ? {4'h0, kq[k]} : 8'hFF;
            chk($sformatf("seq_code%0d", k), got, {4'h0, sk_code[k]});
        end

        // Reset while '0' is held: immediate reset, then re-detected.
        kq.delete();
        keys[3][1] = 1'b1;
        wait_kv(100, ok);
        chk("rh_kv_seen", ok, 1'b1);
        ticks(3);
        chk("rh_pre_held", key_held, 1'b1);
        chk("rh_pre_col", col_n, 4'b1101);
        reset = 1'b1;
        #1;
        chk("rh_col", col_n, 4'b1110);
        chk("rh_held", key_held, 1'b0);
        chk("rh_valid", key_valid, 1'b0);
        chk("rh_code", key_code, 4'h0);
        repeat (3) @(negedge clk);
        kq.delete();
        reset = 1'b0;
        wait_kv(100, ok);
        chk("rh_redetect", ok, 1'b1);
        chk("rh_redetect_code", key_code, 4'h0);
        chk("rh_redetect_held", key_held, 1'b1);
        ticks(10);
        chk("rh_count", kq.size(), 1);
        clear_keys();
        ticks(8);

        chk("kv_rules", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
